// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared parameters and types for the 32-entry MIPS general-purpose register
// file (reg_file32) and its post-reset clear sequencer (regfile_clear_ctrl).
//
// Contents:
//   DATA_W    register width
//   ADDR_W    register index width
//   NUM_REGS  number of architectural registers (2**ADDR_W)
//   ZERO_REG  hard-wired zero register index
//   LAST_IDX  highest register index, used to terminate the clear sweep
//   state_e   clear sequencer states {CLEAR, READY}
//   is_zero_reg() helper that flags accesses to the hard-wired zero register
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 0;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_CLR_IDX = ADDR_W'(1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // True when the index addresses the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
    return (idx == ZERO_IDX);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_clear_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_clear_ctrl
// Post-reset clear sequencer for reg_file32. After reset it sweeps entries
// 1..NUM_REGS-1, one per rising edge, requesting a zero write to each. The
// edge that clears the last entry moves the FSM to READY, which is absorbing
// until the next reset. Entry 0 is never visited because it has no storage.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset; restarts the sweep at entry 1
//   o_clr_we    high while the sweep is writing zeros (CLEAR state)
//   o_clr_addr  entry being cleared on the current edge
//   o_ready     high once every entry has been cleared
// ---------------------------------------------------------------------------
module regfile_clear_ctrl
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              clr_we_q;
  logic              ready_q;

  // Clear FSM: state, sweep counter and both status outputs are registered
  // together so clr_we and ready always change on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= FIRST_CLR_IDX;
      clr_we_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            // Last entry is cleared on this edge; hand over to the datapath.
            state_q  <= READY;
            cnt_q    <= cnt_q;
            clr_we_q <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            state_q  <= CLEAR;
            cnt_q    <= cnt_q + ADDR_W'(1);
            clr_we_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        READY: begin
          state_q  <= READY;
          cnt_q    <= cnt_q;
          clr_we_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fall back to a fresh clear sweep.
          state_q  <= CLEAR;
          cnt_q    <= FIRST_CLR_IDX;
          clr_we_q <= 1'b1;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr_we   = clr_we_q;
  assign o_clr_addr = cnt_q;
  assign o_ready    = ready_q;

endmodule : regfile_clear_ctrl

// File: rtl/reg_file32.sv
// ---------------------------------------------------------------------------
// reg_file32
// General-purpose register file for the single-cycle MIPS datapath: two
// combinational read ports (rs -> ALU A operand, rt -> B-operand mux) and one
// synchronous write port fed by writeback. After reset the array is swept to
// zero by regfile_clear_ctrl; until o_ready rises, reads return 0 and
// external writes are dropped. Register 0 always reads 0 and has no storage.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   -> write-first bypass: in READY, a read whose index matches an
//                accepted write (i_wr_en=1, i_wr_addr!=0) returns i_wr_data in
//                the same cycle.
//   undefined -> read-before-write: the new value is visible the cycle after
//                the write edge.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_rs_addr  read port A index
//   i_rt_addr  read port B index
//   o_rs_data  read port A data
//   o_rt_data  read port B data
//   i_wr_en    write strobe
//   i_wr_addr  write index
//   i_wr_data  write data
//   o_ready    high once the post-reset clear is complete
// ---------------------------------------------------------------------------
module reg_file32
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_ready
);

  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              ready_s;

  regfile_clear_ctrl u_clear_ctrl (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_clr_we   (clr_we_s),
    .o_clr_addr (clr_addr_s),
    .o_ready    (ready_s)
  );

  assign o_ready = ready_s;

  // Entry 0 is declared only to keep indexing uniform; it is never written
  // and never read out, so synthesis removes it.
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              ext_wr_ok_s;
  logic              wr_we_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  assign ext_wr_ok_s = ready_s && i_wr_en && !is_zero_reg(i_wr_addr);

  // Write-port mux: the clear sweep owns the port until ready; afterwards
  // only accepted external writes reach the array.
  always_comb begin
    wr_we_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (clr_we_s) begin
      wr_we_d   = 1'b1;
      wr_addr_d = clr_addr_s;
      wr_data_d = '0;
    end else if (ext_wr_ok_s) begin
      wr_we_d   = 1'b1;
      wr_addr_d = i_wr_addr;
      wr_data_d = i_wr_data;
    end else begin
      wr_we_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
    end
  end

  // Storage array: no reset, contents are established by the clear sweep.
  always_ff @(posedge i_clk) begin
    if (wr_we_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  logic rs_hit_s;
  logic rt_hit_s;

`ifdef REGFILE_BYPASS_EN
  // ext_wr_ok_s already excludes CLEAR and register 0.
  assign rs_hit_s = ext_wr_ok_s && (i_wr_addr == i_rs_addr);
  assign rt_hit_s = ext_wr_ok_s && (i_wr_addr == i_rt_addr);
`else
  assign rs_hit_s = 1'b0;
  assign rt_hit_s = 1'b0;
`endif

  // Read port A: zero while clearing or for r0, else bypass or stored value.
  always_comb begin
    o_rs_data = '0;
    if (!ready_s || is_zero_reg(i_rs_addr)) begin
      o_rs_data = '0;
    end else if (rs_hit_s) begin
      o_rs_data = i_wr_data;
    end else begin
      o_rs_data = mem_q[i_rs_addr];
    end
  end

  // Read port B: same masking and bypass rules as port A.
  always_comb begin
    o_rt_data = '0;
    if (!ready_s || is_zero_reg(i_rt_addr)) begin
      o_rt_data = '0;
    end else if (rt_hit_s) begin
      o_rt_data = i_wr_data;
    end else begin
      o_rt_data = mem_q[i_rt_addr];
    end
  end

endmodule : reg_file32

// File: tb/tb_reg_file32.sv
// ---------------------------------------------------------------------------
// tb_reg_file32
// Self-checking bench for reg_file32. A behavioural model (plain array plus a
// ready flag and an edge count since reset) predicts every read and o_ready.
// ---------------------------------------------------------------------------
module tb_reg_file32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en;
  logic        ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_edges;

  always #5 clk = ~clk;

  reg_file32 dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .o_rs_data (rs_data),
    .o_rt_data (rt_data),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_ready   (ready)
  );

  // Expected read value for an index given current model and inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  // Advance the model by one rising edge using the current inputs.
  function automatic void model_edge();
    if (!m_ready) begin
      m_edges++;
      if (m_edges == 31) begin
        m_ready = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 32'd0;
      end
    end else if (wr_en && wr_addr != 5'd0) begin
      m_mem[wr_addr] = wr_data;
    end
  endfunction

  function automatic void model_reset();
    m_ready = 1'b0;
    m_edges = 0;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    rs_addr = 5'd5; rt_addr = 5'd31;
    model_reset();
    #12;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL reset_reads: got rs=%h rt=%h expected 0", rs_data, rt_data);
    end
    release_reset();
  endtask

  // Clear sweep with a write to r4 held the whole time; it must be dropped.
  task automatic test_clear_hold_write();
    for (int e = 0; e < 31; e++) begin
      rs_addr = 5'd5; rt_addr = 5'd31;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5_A5A5;
      #2;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready edge %0d: got %b expected 0", e, ready); end
      checks++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        errors++; $display("FAIL clear_reads edge %0d: got rs=%h rt=%h expected 0", e, rs_data, rt_data);
      end
      tick();
    end
    wr_en = 1'b0; rs_addr = 5'd4; rt_addr = 5'd4;
    #2;
    checks++;
    if (ready !== 1'b1 || !m_ready) begin errors++; $display("FAIL clear_done: got %b expected 1", ready); end
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL clear_r4_dropped: got rs=%h rt=%h expected 0", rs_data, rt_data);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; rs_addr = 5'd1; rt_addr = 5'd2;
    tick();
    wr_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd7;
    #2;
    checks++;
    if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_read_r7: got rs=%h rt=%h expected deadbeef", rs_data, rt_data);
    end
    tick();
  endtask

  task automatic test_r0();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0; rt_addr = 5'd0;
    #2;
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL r0_same_cycle: got rs=%h rt=%h expected 0", rs_data, rt_data);
    end
    tick();
    wr_en = 1'b0;
    #2;
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL r0_after: got rs=%h rt=%h expected 0", rs_data, rt_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'h1234_5678;
`else
    exp_now = 32'd0;
`endif
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234_5678; rs_addr = 5'd3; rt_addr = 5'd3;
    #2;
    checks++;
    if (rs_data !== exp_now || rt_data !== exp_now) begin
      errors++; $display("FAIL same_cycle_r3: got rs=%h rt=%h expected %h", rs_data, rt_data, exp_now);
    end
    tick();
    wr_en = 1'b0;
    #2;
    checks++;
    if (rs_data !== 32'h1234_5678 || rt_data !== 32'h1234_5678) begin
      errors++; $display("FAIL next_cycle_r3: got rs=%h rt=%h expected 12345678", rs_data, rt_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #2;
      checks++;
      if (rs_data !== exp_rd(rs_addr)) begin
        errors++; $display("FAIL random_rs n=%0d a=%0d: got %h expected %h", n, rs_addr, rs_data, exp_rd(rs_addr));
      end
      checks++;
      if (rt_data !== exp_rd(rt_addr)) begin
        errors++; $display("FAIL random_rt n=%0d a=%0d: got %h expected %h", n, rt_addr, rt_data, exp_rd(rt_addr));
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Fill with index data, reset mid-operation, reset again mid-clear, and
  // confirm the restarted sweep takes 31 edges and leaves everything zero.
  task automatic test_reset_restart();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0; rs_addr = 5'd31; rt_addr = 5'd17;
    #2;
    checks++;
    if (rs_data !== 32'd31 || rt_data !== 32'd17) begin
      errors++; $display("FAIL fill_check: got rs=%h rt=%h expected 1f/11", rs_data, rt_data);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_drop_ready: got %b expected 0", ready); end
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL reset_drop_reads: got rs=%h rt=%h expected 0", rs_data, rt_data);
    end
    release_reset();
    for (int e = 0; e < 10; e++) tick();
    rst_n = 1'b0;
    model_reset();
    release_reset();
    for (int e = 0; e < 31; e++) begin
      #2;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL restart_ready edge %0d: got %b expected 0", e, ready); end
      tick();
    end
    #2;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", ready); end
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        errors++; $display("FAIL restart_zero r%0d: got rs=%h rt=%h expected 0", i, rs_data, rt_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_hold_write();
    test_write_read();
    test_r0();
    test_same_cycle();
    test_random();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file32
